pipeline_hazard_unit: RTL

Parametrised hazard and forwarding controller for the N-stage processor pipeline.
- Tracks in-flight destination registers in an internal scoreboard shift pipeline.
- Generates operand-forwarding selects, load-use stalls and taken-branch flushes for the decode stage.
- Replaces the fixed, single-phase forward cell with depth-generic control that can stall and flush.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_scoreboard.sv | 26 ++
 rtl/pipeline_hazard_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: scoreboard entry, FSM states, forward-select constants.
// Register indices are stored zero-extended to HZ_RD_W bits, so RBITS must not exceed HZ_RD_W.
package hazard_pkg;

  localparam int unsigned HZ_RD_W     = 8;
  localparam int unsigned FWD_REGFILE = 0;

  typedef logic [HZ_RD_W-1:0] hz_rd_t;

  typedef struct packed {
    logic   valid;
    hz_rd_t rd;
    logic   we;
    logic   is_load;
  } sb_entry_t;

  typedef enum logic {HZ_RUN, HZ_FLUSH} hz_state_t;

  function automatic logic sb_match(input sb_entry_t e, input hz_rd_t r, input logic is_reg);
    return is_reg && e.valid && e.we && (e.rd == r);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift pipeline of in-flight destination registers; index 0 is exec, higher indices are older.
// A bubble (all-zero entry) is inserted whenever the decode instruction does not advance.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NSTAGE = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  sb_entry_t              entry,
  output sb_entry_t [NSTAGE-1:0] sb
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb <= '0;
    end else begin
      sb[0] <= push ? entry : '0;
      for (int i = 1; i < NSTAGE; i++) begin
        sb[i] <= sb[i-1];
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller: forward selects, load-use stalls and taken-branch flushes.
// Define HAZARD_PERF_CNT_EN to implement the stall/flush counters; otherwise they read as 0.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter  int RBITS    = 4,
  parameter  int NSTAGE   = 3,
  parameter  int LOAD_LAT = 1,
  parameter  int BR_FLUSH = 2,
  localparam int SELW     = $clog2(NSTAGE+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RBITS-1:0] id_rs_a,
  input  logic             id_rs_a_is_reg,
  input  logic [RBITS-1:0] id_rs_b,
  input  logic             id_rs_b_is_reg,
  input  logic [RBITS-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush,
  output logic [SELW-1:0]  fwd_sel_a,
  output logic [SELW-1:0]  fwd_sel_b,
  output logic [15:0]      stall_count,
  output logic [15:0]      flush_count
);

  sb_entry_t [NSTAGE-1:0] sb;
  sb_entry_t              id_entry;
  hz_state_t              state;
  logic [2:0]             fc;
  logic                   push;
  logic                   hz_a, hz_b;
  logic [SELW-1:0]        sel_a_raw, sel_b_raw;

  assign id_entry = '{valid: 1'b1, rd: hz_rd_t'(id_rd), we: id_we, is_load: id_is_load};
  assign push     = id_valid && !stall && !flush;

  hazard_scoreboard #(.NSTAGE(NSTAGE)) u_scoreboard (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .entry (id_entry),
    .sb    (sb)
  );

  // Scan oldest to youngest so the last hit recorded is the youngest producer.
  function automatic void lookup(input hz_rd_t r, input logic is_reg,
                                 output logic [SELW-1:0] sel, output logic hz);
    logic hit;
    logic ld;
    int   idx;
    hit = 1'b0;
    ld  = 1'b0;
    idx = 0;
    for (int i = NSTAGE-1; i >= 0; i--) begin
      if (sb_match(sb[i], r, is_reg)) begin
        hit = 1'b1;
        ld  = sb[i].is_load;
        idx = i;
      end
    end
    hz  = hit && ld && (idx < LOAD_LAT);
    sel = (hit && !hz) ? SELW'(idx + 1) : SELW'(FWD_REGFILE);
  endfunction

  always_comb begin
    sel_a_raw = '0;
    sel_b_raw = '0;
    hz_a      = 1'b0;
    hz_b      = 1'b0;
    lookup(hz_rd_t'(id_rs_a), id_rs_a_is_reg, sel_a_raw, hz_a);
    lookup(hz_rd_t'(id_rs_b), id_rs_b_is_reg, sel_b_raw, hz_b);
    flush     = rst && ((state == HZ_RUN && ex_branch_taken) || state == HZ_FLUSH);
    stall     = rst && id_valid && (hz_a || hz_b) && !flush;
    fwd_sel_a = rst ? sel_a_raw : '0;
    fwd_sel_b = rst ? sel_b_raw : '0;
  end

  // The RUN cycle that sees the branch is the first bubble, so FLUSH lasts BR_FLUSH-1 cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= HZ_RUN;
      fc    <= '0;
    end else begin
      case (state)
        HZ_RUN: begin
          if (ex_branch_taken && BR_FLUSH > 1) begin
            state <= HZ_FLUSH;
            fc    <= 3'(BR_FLUSH - 1);
          end
        end
        HZ_FLUSH: begin
          fc <= fc - 3'd1;
          if (fc <= 3'd1) state <= HZ_RUN;
        end
        default: state <= HZ_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (state == HZ_RUN && ex_branch_taken && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule
